// File: rtl/fifo_drain.sv
// Read-side engine for the byte FIFO: issues reads, hides the 1-cycle read latency in a
// 2-entry skid buffer and presents a valid/ready stream, with an optional fill-or-timeout burst mode.
module fifo_drain #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              burst_mode_i,
  input  logic              fifo_full_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  byte_count_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_FILL, DRAIN, FLUSH} state_e;

  state_e            state_q;
  logic              burst_q;
  logic [TW-1:0]     timer_q;
  logic              inflight_q;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              pop, cap;
  logic [2:0]        used, limit;

  assign pop          = out_valid_o & out_ready_i;
  assign cap          = inflight_q;
  assign out_valid_o  = (occ_q != 2'd0);
  assign out_data_o   = e0_q;
  assign busy_o       = (state_q != IDLE);
  assign byte_count_o = cnt_q;

  // A pop this cycle frees a slot before the new read's data lands, which keeps 1 byte/cycle.
  assign used  = {1'b0, occ_q} + {2'b0, inflight_q};
  assign limit = 3'd2 + {2'b0, pop};
  assign fifo_rd_en_o = (state_q == DRAIN) & enable_i & ~fifo_empty_i & (used < limit);

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    case ({cap, pop})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = fifo_data_i;
        else               e1_d = fifo_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = fifo_data_i;
        end else begin
          e0_d = fifo_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q      <= 2'd0;
      e0_q       <= '0;
      e1_q       <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      inflight_q <= fifo_rd_en_o;
      if (pop) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      burst_q <= 1'b0;
      timer_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          burst_q <= burst_mode_i;
          timer_q <= '0;
          if (enable_i) state_q <= burst_mode_i ? WAIT_FILL : DRAIN;
        end
        WAIT_FILL: begin
          if (!enable_i)
            state_q <= IDLE;
          else if (fifo_full_i || (timer_q == TW'(TIMEOUT - 1) && !fifo_empty_i))
            state_q <= DRAIN;
          else
            timer_q <= fifo_empty_i ? '0 : timer_q + TW'(1);
        end
        DRAIN: begin
          if (!enable_i)
            state_q <= FLUSH;
          else if (burst_q && fifo_empty_i && occ_q == 2'd0 && !inflight_q)
            state_q <= IDLE;
        end
        FLUSH: begin
          if (occ_q == 2'd0 && !inflight_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain with a 16-deep byte FIFO model on the read side.
module tb_fifo_drain;
  logic       clk = 1'b0;
  logic       rst_n, enable, burst, ready;
  logic       rd_en, out_valid, busy;
  logic [7:0] out_data;
  logic [15:0] bcount;

  logic       wr, mrst;
  logic [7:0] wdata, fdata;
  logic [7:0] mem [16];
  logic [3:0] wp, rp;
  int         fcnt;
  logic       fempty, ffull;

  int checks = 0, fails = 0;
  int cnum = 0, rd_total, rd_empty, run, max_run, first_rd, first_ne, first_full, first_idle;
  int rx_n, stall_err;
  logic [7:0] rx [64];
  logic stalled_prev, s_busy;
  logic [7:0] prev_data;

  always #5 clk = ~clk;

  assign fempty = (fcnt == 0);
  assign ffull  = (fcnt == 16);

  always @(posedge clk) begin
    if (mrst) begin
      fcnt <= 0; wp <= 0; rp <= 0; fdata <= 8'h00;
    end else begin
      if (rd_en && fcnt != 0) begin fdata <= mem[rp]; rp <= rp + 4'd1; end
      if (wr && fcnt != 16) begin mem[wp] <= wdata; wp <= wp + 4'd1; end
      fcnt <= fcnt + ((wr && fcnt != 16) ? 1 : 0) - ((rd_en && fcnt != 0) ? 1 : 0);
    end
  end

  fifo_drain #(.DATA_W(8), .TIMEOUT(16), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .burst_mode_i(burst),
    .fifo_full_i(ffull), .fifo_empty_i(fempty), .fifo_rd_en_o(rd_en), .fifo_data_i(fdata),
    .out_valid_o(out_valid), .out_ready_i(ready), .out_data_o(out_data),
    .busy_o(busy), .byte_count_o(bcount));

  // Sample the current cycle (inputs were set at the preceding negedge), then move to the next negedge.
  task automatic cyc();
    #1;
    s_busy = busy;
    if (rd_en) begin
      rd_total++;
      if (fempty) rd_empty++;
      run++;
      if (run > max_run) max_run = run;
      if (first_rd < 0) first_rd = cnum;
    end else run = 0;
    if (!fempty && first_ne < 0) first_ne = cnum;
    if (ffull && first_full < 0) first_full = cnum;
    if (out_valid && ready && rx_n < 64) begin rx[rx_n] = out_data; rx_n++; end
    if (stalled_prev && out_valid && out_data !== prev_data) stall_err++;
    stalled_prev = out_valid && !ready;
    prev_data = out_data;
    if (first_rd >= 0 && !busy && first_idle < 0) first_idle = cnum;
    cnum++;
    @(negedge clk);
  endtask

  task automatic clear_stats();
    rd_total = 0; rd_empty = 0; run = 0; max_run = 0; first_rd = -1; first_ne = -1;
    first_full = -1; first_idle = -1; rx_n = 0; stall_err = 0; stalled_prev = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mrst = 1'b1; enable = 1'b0; burst = 1'b0; ready = 1'b0; wr = 1'b0; wdata = 8'h00;
    cyc(); cyc();
    rst_n = 1'b1; mrst = 1'b0;
    cyc();
    clear_stats();
  endtask

  task automatic preload(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr = 1'b1; wdata = base + 8'(i);
      cyc();
    end
    wr = 1'b0;
    clear_stats();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mrst = 1'b1; enable = 1'b1; burst = 1'b0; ready = 1'b1; wr = 1'b0; wdata = 8'h00;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bcount !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bcount); end
    checks++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", out_data); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    int bad = 0;
    do_reset(); preload(8'h10, 16);
    enable = 1'b1; ready = 1'b1;
    for (int i = 0; i < 24; i++) cyc();
    for (int i = 0; i < 16; i++) if (rx[i] !== 8'h10 + 8'(i)) bad++;
    checks++; if (max_run !== 16) begin fails++; $display("FAIL t1_consec_reads: got %0d want 16", max_run); end
    checks++; if (rd_total !== 16) begin fails++; $display("FAIL t1_reads: got %0d want 16", rd_total); end
    checks++; if (rx_n !== 16) begin fails++; $display("FAIL t1_delivered: got %0d want 16", rx_n); end
    checks++; if (bad !== 0) begin fails++; $display("FAIL t1_order: got %0d bad bytes want 0", bad); end
    checks++; if (bcount !== 16'd16) begin fails++; $display("FAIL t1_count: got %0d want 16", bcount); end
    checks++; if (rd_empty !== 0) begin fails++; $display("FAIL t1_rd_while_empty: got %0d want 0", rd_empty); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL t1_busy: got %b want 1", busy); end
  endtask

  task automatic test_stall();
    int bad = 0;
    do_reset(); preload(8'h40, 16);
    enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ready = (i % 3 == 0);
      cyc();
    end
    for (int i = 0; i < 16; i++) if (rx[i] !== 8'h40 + 8'(i)) bad++;
    checks++; if (rx_n !== 16) begin fails++; $display("FAIL t2_delivered: got %0d want 16", rx_n); end
    checks++; if (bad !== 0) begin fails++; $display("FAIL t2_order: got %0d bad bytes want 0", bad); end
    checks++; if (stall_err !== 0) begin fails++; $display("FAIL t2_stall_stable: got %0d changes want 0", stall_err); end
    checks++; if (bcount !== 16'd16) begin fails++; $display("FAIL t2_count: got %0d want 16", bcount); end
    checks++; if (rd_total !== 16) begin fails++; $display("FAIL t2_reads: got %0d want 16", rd_total); end
  endtask

  task automatic test_burst_full();
    int bad = 0;
    do_reset();
    enable = 1'b1; burst = 1'b1; ready = 1'b1;
    cyc(); cyc();
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; wdata = 8'h80 + 8'(i);
      cyc();
    end
    wr = 1'b0;
    for (int i = 0; i < 30; i++) cyc();
    for (int i = 0; i < 16; i++) if (rx[i] !== 8'h80 + 8'(i)) bad++;
    checks++; if (first_rd !== first_full + 1) begin fails++; $display("FAIL t3_first_read: got %0d want %0d", first_rd, first_full + 1); end
    checks++; if (rx_n !== 16 || bad !== 0) begin fails++; $display("FAIL t3_data: got %0d bytes %0d bad want 16 0", rx_n, bad); end
    checks++; if (first_idle !== first_full + 20) begin fails++; $display("FAIL t3_idle: got %0d want %0d", first_idle, first_full + 20); end
    checks++; if (bcount !== 16'd16) begin fails++; $display("FAIL t3_count: got %0d want 16", bcount); end
  endtask

  task automatic test_burst_timeout();
    int bad = 0;
    do_reset();
    enable = 1'b1; burst = 1'b1; ready = 1'b1;
    cyc(); cyc();
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; wdata = 8'hC0 + 8'(i);
      cyc();
    end
    wr = 1'b0;
    for (int i = 0; i < 30; i++) cyc();
    for (int i = 0; i < 3; i++) if (rx[i] !== 8'hC0 + 8'(i)) bad++;
    checks++; if (first_rd - first_ne !== 16) begin fails++; $display("FAIL t4_timeout: got %0d want 16", first_rd - first_ne); end
    checks++; if (rx_n !== 3 || bad !== 0) begin fails++; $display("FAIL t4_data: got %0d bytes %0d bad want 3 0", rx_n, bad); end
    checks++; if (first_idle < 0) begin fails++; $display("FAIL t4_idle: got %0d want >=0", first_idle); end
    checks++; if (rd_total !== 3) begin fails++; $display("FAIL t4_reads: got %0d want 3", rd_total); end
  endtask

  task automatic test_disable();
    int bad = 0;
    do_reset(); preload(8'h20, 16);
    enable = 1'b1; ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (rd_total == 4) break;
    end
    enable = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    checks++; if (s_busy !== 1'b0) begin fails++; $display("FAIL t5_idle_in_3: got busy=%b want 0", s_busy); end
    for (int i = 0; i < 6; i++) cyc();
    for (int i = 0; i < 4; i++) if (rx[i] !== 8'h20 + 8'(i)) bad++;
    checks++; if (rd_total !== 4) begin fails++; $display("FAIL t5_reads: got %0d want 4", rd_total); end
    checks++; if (rx_n !== 4 || bad !== 0) begin fails++; $display("FAIL t5_data: got %0d bytes %0d bad want 4 0", rx_n, bad); end
    checks++; if (bcount !== 16'd4) begin fails++; $display("FAIL t5_count: got %0d want 4", bcount); end
  endtask

  task automatic test_async_reset();
    do_reset(); preload(8'h60, 16);
    enable = 1'b1; ready = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    checks++; if (bcount !== 16'(rx_n) || rx_n == 0) begin fails++; $display("FAIL t6_pre_count: got %0d want %0d", bcount, rx_n); end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t6_pre_valid: got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t6_valid: got %b want 0", out_valid); end
    checks++; if (rd_en !== 1'b0) begin fails++; $display("FAIL t6_rd_en: got %b want 0", rd_en); end
    checks++; if (bcount !== 16'd0) begin fails++; $display("FAIL t6_count: got %0d want 0", bcount); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL t6_busy: got %b want 0", busy); end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(); cyc();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL t6_after: got busy=%b valid=%b want 0 0", busy, out_valid); end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_stream();
    test_stall();
    test_burst_full();
    test_burst_timeout();
    test_disable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
